// File: rtl/serial_flow_pkg.sv
// Shared types for the serial flow ALU: operation modes and word-framing states.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package serial_flow_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_SUB = 2'd1,
    MODE_CMP = 2'd2
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Raw 2-bit mode pin to operation; the unused encoding 2'b11 falls back to ADD.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_SUB;
      2'b10:   return MODE_CMP;
      default: return MODE_ADD;
    endcase
  endfunction

endpackage

// File: rtl/serial_flow_alu_if.sv
// Bundles the serial operand inputs, the control inputs and the result/status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; in_valid qualifies data and the engine always accepts a valid bit.
interface serial_flow_alu_if;
  logic       in_valid;
  logic       line1;
  logic       line2;
  logic [1:0] mode;
  logic       abort;
  logic       ovf_clr;
  logic       outp;
  logic       out_valid;
  logic       word_done;
  logic       overflw;
  logic       cmp_eq;
  logic       cmp_gt;
  logic       ovf_sticky;

  // Driver side: the serial line receivers and control logic.
  modport master (
    output in_valid, line1, line2, mode, abort, ovf_clr,
    input  outp, out_valid, word_done, overflw, cmp_eq, cmp_gt, ovf_sticky
  );

  // Engine side.
  modport slave (
    input  in_valid, line1, line2, mode, abort, ovf_clr,
    output outp, out_valid, word_done, overflw, cmp_eq, cmp_gt, ovf_sticky
  );
endinterface

// File: rtl/serial_flow_bitcell.sv
// One-bit full adder plus compare slice; SUB inverts operand B here.
// Latency: combinational.
// Backpressure: n/a.
module serial_flow_bitcell
  import serial_flow_pkg::*;
(
  input  logic  a_i,
  input  logic  b_i,
  input  logic  c_i,
  input  mode_e mode_i,
  output logic  sum_o,
  output logic  carry_o,
  output logic  diff_o
);

  logic b_eff;

  // Two's-complement subtract is A + ~B + 1; the +1 comes in as the initial carry.
  always_comb begin
    b_eff   = (mode_i == MODE_SUB) ? ~b_i : b_i;
    sum_o   = a_i ^ b_eff ^ c_i;
    carry_o = (a_i & b_eff) | (a_i & c_i) | (b_eff & c_i);
    diff_o  = a_i ^ b_i;
  end

endmodule

// File: rtl/serial_flow_alu.sv
// Bit-serial add/sub/compare of two LSB-first streams framed into WORD_W-bit words.
// Latency: 1 cycle from a consumed bit to outp/out_valid; word flags arrive with the last bit.
// Backpressure: none; every in_valid bit is consumed unless abort is high in the same cycle.
module serial_flow_alu
  import serial_flow_pkg::*;
#(
  parameter  int WORD_W = 8,
  localparam int CNT_W  = $clog2(WORD_W)
) (
  input logic              clock,
  input logic              reset,
  serial_flow_alu_if.slave bus
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  mode_e              mode_q;
  logic               carry_q;
  logic               eq_q;
  logic               gt_q;
  logic               outp_q;
  logic               out_valid_q;
  logic               word_done_q;
  logic               overflw_q;
  logic               cmp_eq_q;
  logic               cmp_gt_q;
  logic               sticky_q;

  logic               first;
  logic               last;
  mode_e              mode_d;
  logic               c_in;
  logic               eq_in;
  logic               gt_in;
  logic               sum;
  logic               cout;
  logic               diff;
  logic               eq_d;
  logic               gt_d;
  logic               res_d;
  logic               ovf_d;

  serial_flow_bitcell u_cell (
    .a_i     (bus.line1),
    .b_i     (bus.line2),
    .c_i     (c_in),
    .mode_i  (mode_d),
    .sum_o   (sum),
    .carry_o (cout),
    .diff_o  (diff)
  );

  // On the first bit of a word take mode from the pin and seed carry/compare state fresh.
  always_comb begin
    first  = (state_q == ST_IDLE);
    last   = (state_q == ST_RUN) && (cnt_q == CNT_W'(WORD_W - 1));
    mode_d = first ? decode_mode(bus.mode) : mode_q;
    c_in   = first ? (mode_d == MODE_SUB) : carry_q;
    eq_in  = first ? 1'b1 : eq_q;
    gt_in  = first ? 1'b0 : gt_q;
    // Higher differing bits overwrite the verdict of lower ones.
    eq_d   = eq_in & ~diff;
    gt_d   = diff ? bus.line1 : gt_in;
    res_d  = (mode_d == MODE_CMP) ? diff : sum;
    case (mode_d)
      MODE_ADD: ovf_d = cout;
      MODE_SUB: ovf_d = ~cout;
      default:  ovf_d = 1'b0;
    endcase
  end

  // Word framing FSM with registered result and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_ADD;
      carry_q     <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      outp_q      <= 1'b0;
      out_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      overflw_q   <= 1'b0;
      cmp_eq_q    <= 1'b0;
      cmp_gt_q    <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      outp_q      <= 1'b0;
      out_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      overflw_q   <= 1'b0;
      cmp_eq_q    <= 1'b0;
      cmp_gt_q    <= 1'b0;
      // A pulse seen together with a clear still leaves the sticky bit set.
      sticky_q    <= overflw_q | (sticky_q & ~bus.ovf_clr);
      if (bus.abort) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else if (bus.in_valid) begin
        outp_q      <= res_d;
        out_valid_q <= 1'b1;
        mode_q      <= mode_d;
        carry_q     <= cout;
        eq_q        <= eq_d;
        gt_q        <= gt_d;
        if (last) begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          word_done_q <= 1'b1;
          overflw_q   <= ovf_d;
          cmp_eq_q    <= eq_d;
          cmp_gt_q    <= gt_d;
        end else begin
          state_q <= ST_RUN;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.outp       = outp_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.word_done  = word_done_q;
  assign bus.overflw    = overflw_q;
  assign bus.cmp_eq     = cmp_eq_q;
  assign bus.cmp_gt     = cmp_gt_q;
  assign bus.ovf_sticky = sticky_q;

endmodule

// File: doc/serial_flow_alu.md
# serial_flow_alu

Parametrised bit-serial two-stream arithmetic/compare engine: consumes two LSB-first serial flows on `line1`/`line2`, frames them into `WORD_W`-bit words, and per word produces a serial result stream plus end-of-word flags (overflow/borrow, equal, greater). Generalises the fixed two-line serial-flow comparator FSM to configurable word length, runtime-selectable mode (add / subtract / compare), valid-qualified input with gaps, abort, and sticky overflow status. It sits between serial line receivers and the status/control logic.

## Interface
Parameters:
- `WORD_W`, 8, bits per word (2..64)
- `CNT_W`, $clog2(WORD_W), bit-counter width (derived, not overridden)

Ports:
- `clock` in 1: single clock, all state on rising edge
- `reset` in 1: reset is synchronous and active-high
- `in_valid` in 1: qualifies `line1`/`line2` this cycle
- `line1` in 1: operand A serial bit, LSB first
- `line2` in 1: operand B serial bit, LSB first
- `mode` in 2: operation, sampled on first bit of word only
- `abort` in 1: discard word in progress
- `ovf_clr` in 1: clear `ovf_sticky`
- `outp` out 1: serial result bit
- `out_valid` out 1: `outp` valid
- `word_done` out 1: pulse with last result bit of a word
- `overflw` out 1: carry-out (ADD) / borrow (SUB), valid with `word_done`
- `cmp_eq` out 1: A == B, valid with `word_done`
- `cmp_gt` out 1: A > B unsigned, valid with `word_done`
- `ovf_sticky` out 1: set by any `overflw` pulse

## Operation
- Reset: all outputs 0, state IDLE, bit count 0, carry 0, `ovf_sticky` 0.
- States: IDLE (no word open), RUN (1..WORD_W-1 bits consumed). IDLE→RUN on valid bit when WORD_W>1; RUN→IDLE on the WORD_W-th valid bit, or on `abort`.
- `in_valid`=0: state, count, carry, compare regs hold; `out_valid`=0.
- First valid bit latches `mode`; later `mode` changes ignored until next word. `2'b11` behaves as ADD.
- ADD: carry init 0; `outp` = a^b^c; c' = maj(a,b,c); `overflw` = final carry.
- SUB (A−B): b inverted, carry init 1; `overflw` = NOT final carry (borrow).
- CMP: `outp` = a^b (difference mask); eq cleared on any differing bit; gt <= a on each differing bit (higher bits overwrite lower).
- `cmp_eq`/`cmp_gt` computed in all modes; `overflw` forced 0 in CMP.
- `abort`: takes priority over `in_valid` same cycle; bit not consumed; word discarded, no `word_done`, return to IDLE, carry/compare regs reinitialised on next first bit.
- `ovf_sticky`: set when `overflw` pulses; `ovf_clr` clears; simultaneous set and clear → set wins.
- Flags `word_done`, `overflw`, `cmp_eq`, `cmp_gt` are 0 except in the `word_done` cycle.

## Timing
- Latency 1: bit consumed at edge k → `outp`/`out_valid` at cycle k+1.
- `word_done` and flags coincide with `out_valid` for the last bit.
- Back-to-back words: first bit of next word accepted the cycle after last bit of previous; no bubble; throughput 1 bit/cycle.
- Reset mid-word: next cycle all outputs 0, partial word lost, no `word_done`.
- Arbitrary `in_valid` gaps inside a word do not change results.

## Structure
- Package `serial_flow_pkg`: mode enum (`MODE_ADD`=0, `MODE_SUB`=1, `MODE_CMP`=2), state enum (`ST_IDLE`, `ST_RUN`).
- Sub-module `serial_flow_bitcell`: combinational full-adder + compare slice (a, b, c, mode → sum, carry, diff); top holds FSM, counter, registers.

## Test plan
- WORD_W=8, ADD 0xF0+0x20 contiguous → serial result 0x10, `overflw`=1, `word_done` on 8th output cycle, `ovf_sticky`=1.
- SUB 0x05−0x07 → 0xFE, `overflw`=1; SUB 0x07−0x05 → 0x02, `overflw`=0.
- CMP 0x81 vs 0x7F → `outp` mask 0xFE, `cmp_gt`=1, `cmp_eq`=0; CMP 0x3C vs 0x3C → `cmp_eq`=1, `cmp_gt`=0.
- ADD 0x0F+0x01 with `in_valid` low every other cycle, then immediate back-to-back 0xFF+0x01 → 0x10 (`overflw`=0), then 0x00 (`overflw`=1), no bubble.
- `abort` at bit 4 of a word, then full word 0x12+0x34 → no `word_done` for aborted word, next result 0x46; repeat with `reset` at bit 4 → outputs 0 next cycle.
- `ovf_clr` asserted in same cycle as an `overflw` pulse → `ovf_sticky`=1; `ovf_clr` alone next cycle → 0.
